// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory SRAM controller: FSM state
// encoding, default SRAM address width and inactive strobe levels.
package dmem_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    WR    = 3'd2,
    WHOLD = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam int         DEFAULT_SRAM_AW = 20;
  localparam logic       STROBE_INACTIVE = 1'b1;
  localparam logic [3:0] BE_INACTIVE     = 4'b1111;

endpackage

// File: rtl/sram_wait_cnt.sv
// Access-strobe wait counter: reloads to WAIT_CYCLES-1 on each accepted
// request, counts down while an SRAM cycle is in progress and stops at 0.
// done is high whenever the count has reached zero.
module sram_wait_cnt #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam logic [3:0] RELOAD = 4'(WAIT_CYCLES - 1);

  logic [3:0] count;

  // Reload on acceptance, otherwise count down and saturate at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= RELOAD;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign done = (count == 4'd0);

endmodule

// File: rtl/dmem_sram_ctrl.sv
// CPU data-memory to asynchronous SRAM controller. One request at a time:
// loads hold CE/OE low for WAIT_CYCLES clocks then present the sampled word
// in a one-cycle response; stores hold CE/WE low for WAIT_CYCLES clocks,
// then spend one hold cycle (WE released, address/data still driven) in
// which the completion response is given. All outputs are registered.
// Optional build macro DMEM_ALIGN_CHECK_EN: misaligned requests skip the
// SRAM and answer the next cycle with resp_err=1.
module dmem_sram_ctrl
  import dmem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = DEFAULT_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic               req_we,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  input  logic [3:0]         req_be,
  output logic               req_ready,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic               resp_err,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  output logic               sram_wdata_oe,
  input  logic [31:0]        sram_rdata,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n
);

  state_t state;
  logic   accept;
  logic   cnt_done;
  logic   unused_addr;

  assign accept      = req_valid && (state == IDLE);
  assign unused_addr = ^{req_addr[31:SRAM_AW+2], req_addr[1:0]};

  sram_wait_cnt #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .dec  ((state == RD) || (state == WR)),
    .done (cnt_done)
  );

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q;
  logic misaligned;
  assign misaligned = (req_addr[1:0] != 2'b00);
  assign resp_err   = err_q;
`else
  assign resp_err   = 1'b0;
`endif

  // Request sequencing FSM driving every registered SRAM strobe and response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= 32'd0;
      sram_addr     <= '0;
      sram_wdata    <= 32'd0;
      sram_wdata_oe <= 1'b0;
      sram_ce_n     <= STROBE_INACTIVE;
      sram_oe_n     <= STROBE_INACTIVE;
      sram_we_n     <= STROBE_INACTIVE;
      sram_be_n     <= BE_INACTIVE;
`ifdef DMEM_ALIGN_CHECK_EN
      err_q         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
            if (misaligned) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              err_q      <= 1'b1;
            end else
`endif
            begin
              sram_addr <= req_addr[SRAM_AW+1:2];
              sram_ce_n <= 1'b0;
              if (req_we) begin
                state         <= WR;
                sram_we_n     <= 1'b0;
                sram_oe_n     <= STROBE_INACTIVE;
                sram_be_n     <= ~req_be;
                sram_wdata    <= req_wdata;
                sram_wdata_oe <= 1'b1;
              end else begin
                state     <= RD;
                sram_oe_n <= 1'b0;
                sram_be_n <= 4'b0000;
              end
            end
          end
        end

        RD: begin
          if (cnt_done) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= sram_rdata;
            sram_ce_n  <= STROBE_INACTIVE;
            sram_oe_n  <= STROBE_INACTIVE;
            sram_be_n  <= BE_INACTIVE;
          end
        end

        WR: begin
          if (cnt_done) begin
            state      <= WHOLD;
            sram_we_n  <= STROBE_INACTIVE;
            resp_valid <= 1'b1;
          end
        end

        WHOLD: begin
          state         <= IDLE;
          req_ready     <= 1'b1;
          resp_valid    <= 1'b0;
          sram_ce_n     <= STROBE_INACTIVE;
          sram_be_n     <= BE_INACTIVE;
          sram_wdata_oe <= 1'b0;
        end

        RESP: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
          err_q      <= 1'b0;
`endif
        end

        default: begin
          state         <= IDLE;
          req_ready     <= 1'b1;
          resp_valid    <= 1'b0;
          sram_wdata_oe <= 1'b0;
          sram_ce_n     <= STROBE_INACTIVE;
          sram_oe_n     <= STROBE_INACTIVE;
          sram_we_n     <= STROBE_INACTIVE;
          sram_be_n     <= BE_INACTIVE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_sram_ctrl.sv
// Directed self-checking bench for dmem_sram_ctrl with WAIT_CYCLES=2.
// Honors DMEM_ALIGN_CHECK_EN for the misaligned-request scenario.
module tb_dmem_sram_ctrl;

  localparam int W  = 2;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_we;
  logic [31:0]   req_addr, req_wdata;
  logic [3:0]    req_be;
  logic          req_ready, resp_valid, resp_err;
  logic [31:0]   resp_rdata;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata, sram_rdata;
  logic          sram_wdata_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]    sram_be_n;

  int total = 0;
  int bad   = 0;

  int            lat, ce_low, oe_low, we_low, whold_cnt, resp_cnt;
  logic [31:0]   rsp_data, wdata_seen;
  logic          rsp_err, resp_in_whold, oe_seen;
  logic [3:0]    rd_be, wr_be;
  logic [AW-1:0] addr_seen;

  dmem_sram_ctrl #(.WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_be        (req_be),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .sram_addr     (sram_addr),
    .sram_wdata    (sram_wdata),
    .sram_wdata_oe (sram_wdata_oe),
    .sram_rdata    (sram_rdata),
    .sram_ce_n     (sram_ce_n),
    .sram_oe_n     (sram_oe_n),
    .sram_we_n     (sram_we_n),
    .sram_be_n     (sram_be_n)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accept the pending request, scramble the request inputs, then gather
  // strobe and response statistics over the following eight cycles
  task automatic run_txn;
    lat = 0; ce_low = 0; oe_low = 0; we_low = 0; whold_cnt = 0; resp_cnt = 0;
    rsp_data = 32'hx; rsp_err = 1'bx; resp_in_whold = 1'b0;
    rd_be = 4'hx; wr_be = 4'hx;
    tick();
    addr_seen  = sram_addr;
    wdata_seen = sram_wdata;
    oe_seen    = sram_wdata_oe;
    req_valid  = 1'b0;
    req_addr   = ~req_addr;
    req_wdata  = ~req_wdata;
    req_be     = ~req_be;
    for (int i = 0; i < 8; i++) begin
      if (!sram_ce_n) ce_low++;
      if (!sram_oe_n) begin oe_low++; rd_be = sram_be_n; end
      if (!sram_we_n) begin we_low++; wr_be = sram_be_n; end
      if (!sram_ce_n && sram_we_n && sram_wdata_oe) whold_cnt++;
      if (resp_valid) begin
        resp_cnt++;
        if (lat == 0) lat = i + 1;
        rsp_data = resp_rdata;
        rsp_err  = resp_err;
        if (!sram_ce_n && sram_we_n) resp_in_whold = 1'b1;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; sram_rdata = '0;
    #1 rst = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_ready got %b need 1", req_ready); end
    total++; if ({resp_valid, resp_err} !== 2'b00) begin bad++; $display("[TB] FAIL rst_resp got %b need 00", {resp_valid, resp_err}); end
    total++; if (resp_rdata !== 32'd0) begin bad++; $display("[TB] FAIL rst_rdata got %h need 0", resp_rdata); end
    total++; if ({sram_addr, sram_wdata, sram_wdata_oe} !== '0) begin bad++; $display("[TB] FAIL rst_sram_bus addr=%h wdata=%h oe=%b need zeros", sram_addr, sram_wdata, sram_wdata_oe); end
    total++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n} !== 7'h7F) begin bad++; $display("[TB] FAIL rst_strobes got %b need 1111111", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n}); end
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic test_load;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0010; sram_rdata = 32'hDEADBEEF;
    total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL load_ready got %b need 1", req_ready); end
    run_txn();
    total++; if (addr_seen !== 20'h4) begin bad++; $display("[TB] FAIL load_addr got %h need 4", addr_seen); end
    total++; if (oe_low !== W) begin bad++; $display("[TB] FAIL load_oe_cycles got %0d need %0d", oe_low, W); end
    total++; if (rd_be !== 4'b0000) begin bad++; $display("[TB] FAIL load_be_n got %b need 0000", rd_be); end
    total++; if (we_low !== 0) begin bad++; $display("[TB] FAIL load_we_cycles got %0d need 0", we_low); end
    total++; if (lat !== W + 1) begin bad++; $display("[TB] FAIL load_latency got %0d need %0d", lat, W + 1); end
    total++; if (resp_cnt !== 1) begin bad++; $display("[TB] FAIL load_resp_count got %0d need 1", resp_cnt); end
    total++; if (rsp_data !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL load_rdata got %h need deadbeef", rsp_data); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("[TB] FAIL load_err got %b need 0", rsp_err); end
    sram_rdata = 32'h0;
    tick();
    total++; if (resp_rdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL load_rdata_hold got %h need deadbeef", resp_rdata); end
  endtask

  task automatic test_store;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'b0011;
    run_txn();
    total++; if (addr_seen !== 20'h8) begin bad++; $display("[TB] FAIL store_addr got %h need 8", addr_seen); end
    total++; if ({wdata_seen, oe_seen} !== {32'h12345678, 1'b1}) begin bad++; $display("[TB] FAIL store_wdata got %h oe=%b need 12345678 oe=1", wdata_seen, oe_seen); end
    total++; if (we_low !== W) begin bad++; $display("[TB] FAIL store_we_cycles got %0d need %0d", we_low, W); end
    total++; if (wr_be !== 4'b1100) begin bad++; $display("[TB] FAIL store_be_n got %b need 1100", wr_be); end
    total++; if (oe_low !== 0) begin bad++; $display("[TB] FAIL store_oe_cycles got %0d need 0", oe_low); end
    total++; if (whold_cnt !== 1) begin bad++; $display("[TB] FAIL store_hold_cycles got %0d need 1", whold_cnt); end
    total++; if (resp_in_whold !== 1'b1) begin bad++; $display("[TB] FAIL store_resp_in_hold got %b need 1", resp_in_whold); end
    total++; if (lat !== W + 1) begin bad++; $display("[TB] FAIL store_latency got %0d need %0d", lat, W + 1); end
    total++; if ({sram_ce_n, sram_we_n, sram_wdata_oe} !== 3'b110) begin bad++; $display("[TB] FAIL store_idle_after got ce/we/oe=%b need 110", {sram_ce_n, sram_we_n, sram_wdata_oe}); end
  endtask

  task automatic test_back_to_back;
    int acc_time[3];
    int n;
    int low_cnt;
    int rcnt;
    n = 0; low_cnt = 0; rcnt = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; sram_rdata = 32'h0BADF00D;
    for (int cyc = 0; cyc < 24; cyc++) begin
      logic took;
      took = 1'b0;
      if (resp_valid) rcnt++;
      if (n >= 1 && n < 3 && !req_ready) low_cnt++;
      if (req_valid && req_ready && n < 3) begin
        acc_time[n] = cyc;
        n++;
        took = 1'b1;
      end
      tick();
      if (took) begin
        if (n == 3) req_valid = 1'b0;
        else req_addr = 32'h100 + 32'(4 * n);
      end
    end
    total++; if (n !== 3) begin bad++; $display("[TB] FAIL b2b_accepts got %0d need 3", n); end
    if (n == 3) begin
      total++; if (acc_time[1] - acc_time[0] !== W + 2) begin bad++; $display("[TB] FAIL b2b_spacing1 got %0d need %0d", acc_time[1] - acc_time[0], W + 2); end
      total++; if (acc_time[2] - acc_time[1] !== W + 2) begin bad++; $display("[TB] FAIL b2b_spacing2 got %0d need %0d", acc_time[2] - acc_time[1], W + 2); end
    end
    total++; if (low_cnt !== 2 * (W + 1)) begin bad++; $display("[TB] FAIL b2b_ready_low got %0d need %0d", low_cnt, 2 * (W + 1)); end
    total++; if (rcnt !== 3) begin bad++; $display("[TB] FAIL b2b_responses got %0d need 3", rcnt); end
  endtask

  task automatic test_reset_mid_write;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hFFFF0000; req_be = 4'b1111;
    tick();
    req_valid = 1'b0;
    tick();
    total++; if (sram_we_n !== 1'b0) begin bad++; $display("[TB] FAIL midwr_in_write got we_n=%b need 0", sram_we_n); end
    rst = 1'b0;
    #1;
    total++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_wdata_oe} !== 8'hFE) begin bad++; $display("[TB] FAIL midwr_strobes got %b need 11111110", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_wdata_oe}); end
    total++; if ({resp_valid, req_ready} !== 2'b01) begin bad++; $display("[TB] FAIL midwr_resp_ready got %b need 01", {resp_valid, req_ready}); end
    total++; if (sram_addr !== '0) begin bad++; $display("[TB] FAIL midwr_addr got %h need 0", sram_addr); end
    tick();
    total++; if (resp_valid !== 1'b0) begin bad++; $display("[TB] FAIL midwr_no_resp got %b need 0", resp_valid); end
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; sram_rdata = 32'h5A5A1234;
    run_txn();
    total++; if (addr_seen !== 20'h10) begin bad++; $display("[TB] FAIL post_rst_addr got %h need 10", addr_seen); end
    total++; if (lat !== W + 1) begin bad++; $display("[TB] FAIL post_rst_latency got %0d need %0d", lat, W + 1); end
    total++; if (rsp_data !== 32'h5A5A1234) begin bad++; $display("[TB] FAIL post_rst_rdata got %h need 5a5a1234", rsp_data); end
  endtask

  task automatic test_be_zero;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h24; req_wdata = 32'hA5A5A5A5; req_be = 4'b0000;
    run_txn();
    total++; if (we_low !== W) begin bad++; $display("[TB] FAIL bez_we_cycles got %0d need %0d", we_low, W); end
    total++; if (wr_be !== 4'b1111) begin bad++; $display("[TB] FAIL bez_be_n got %b need 1111", wr_be); end
    total++; if (resp_in_whold !== 1'b1) begin bad++; $display("[TB] FAIL bez_resp_in_hold got %b need 1", resp_in_whold); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("[TB] FAIL bez_err got %b need 0", rsp_err); end
  endtask

  task automatic test_unaligned;
    logic [31:0] prev;
    prev = resp_rdata;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h13; sram_rdata = 32'hCAFEF00D;
    run_txn();
`ifdef DMEM_ALIGN_CHECK_EN
    total++; if (ce_low !== 0) begin bad++; $display("[TB] FAIL unal_ce_cycles got %0d need 0", ce_low); end
    total++; if (lat !== 1) begin bad++; $display("[TB] FAIL unal_latency got %0d need 1", lat); end
    total++; if (rsp_err !== 1'b1) begin bad++; $display("[TB] FAIL unal_err got %b need 1", rsp_err); end
    total++; if (rsp_data !== prev) begin bad++; $display("[TB] FAIL unal_rdata got %h need %h", rsp_data, prev); end
`else
    total++; if (addr_seen !== 20'h4) begin bad++; $display("[TB] FAIL unal_addr got %h need 4", addr_seen); end
    total++; if (ce_low !== W) begin bad++; $display("[TB] FAIL unal_ce_cycles got %0d need %0d", ce_low, W); end
    total++; if (lat !== W + 1) begin bad++; $display("[TB] FAIL unal_latency got %0d need %0d", lat, W + 1); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("[TB] FAIL unal_err got %b need 0", rsp_err); end
    total++; if (rsp_data !== 32'hCAFEF00D) begin bad++; $display("[TB] FAIL unal_rdata got %h need cafef00d (prev %h)", rsp_data, prev); end
`endif
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_reset_mid_write();
    test_be_zero();
    test_unaligned();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Run-time guard
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/dmem_sram_ctrl.md
DMEM_SRAM_CTRL -- requirements
Module: dmem_sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SHALL set SRAM access strobe length in clocks (legal 1..15).
REQ-002 Parameter SRAM_AW, default 20, SHALL set SRAM word-address width.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: asynchronous assertion, active-low.
REQ-005 req_valid  in  1  SHALL indicate a CPU load/store request.
REQ-006 req_we  in  1  SHALL select store (1) or load (0).
REQ-007 req_addr  in  32  SHALL carry the byte address.
REQ-008 req_wdata  in  32  SHALL carry the store data.
REQ-009 req_be  in  4  SHALL carry the store byte enables (bit n = byte n).
REQ-010 req_ready  out  1  SHALL indicate the block can accept a request.
REQ-011 resp_valid  out  1  SHALL pulse one cycle on load data valid or store complete.
REQ-012 resp_rdata  out  32  SHALL carry load data, valid while resp_valid=1.
REQ-013 resp_err  out  1  SHALL flag a rejected request, qualified by resp_valid.
REQ-014 sram_addr  out  SRAM_AW  SHALL be the SRAM word address (req_addr[SRAM_AW+1:2]).
REQ-015 sram_wdata / sram_wdata_oe  out  32 / 1  SHALL be the write data and its tristate enable.
REQ-016 sram_rdata  in  32  SHALL be the SRAM read data.
REQ-017 sram_ce_n, sram_oe_n, sram_we_n  out  1 each; sram_be_n  out  4  SHALL be active-low SRAM strobes.

Function
REQ-018 Acceptance SHALL occur on a rising edge with req_valid=1 and req_ready=1; req_we/addr/wdata/be SHALL be registered then, later input changes ignored.
REQ-019 FSM states SHALL be IDLE, RD, WR, WHOLD, RESP; req_ready=1 only in IDLE.
REQ-020 IDLE->RD (load) or IDLE->WR (store) on acceptance; otherwise stay IDLE with all strobes high, sram_wdata_oe=0.
REQ-021 RD: ce_n=0, oe_n=0, be_n=4'b0000 for exactly WAIT_CYCLES cycles; sram_rdata SHALL be sampled on the last RD edge; then RESP.
REQ-022 RESP: resp_valid=1, resp_rdata=sampled word, strobes high; next state IDLE.
REQ-023 WR: ce_n=0, we_n=0, oe_n=1, be_n=~req_be, sram_wdata_oe=1 for exactly WAIT_CYCLES cycles; then WHOLD.
REQ-024 WHOLD: ce_n=0, we_n=1, address/data/oe still driven (hold time), resp_valid=1; next state IDLE.
REQ-025 Latency SHALL be WAIT_CYCLES+1 clocks from acceptance edge to resp_valid; throughput one request per WAIT_CYCLES+2 clocks.
REQ-026 Store with req_be=4'b0000 SHALL run a full write cycle with be_n=4'b1111 and complete normally.
REQ-027 resp_rdata SHALL hold its last value outside RESP; resp_err=0 on every non-error response.
REQ-028 Wait counter SHALL count WAIT_CYCLES-1 down to 0 and reload on every acceptance; no wrap beyond 0.

Reset
REQ-029 rst=0 SHALL immediately force IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, sram_addr=0, sram_wdata=0, sram_wdata_oe=0, all *_n=1.
REQ-030 Reset mid-access SHALL abort the SRAM cycle with no response; first acceptance allowed on the first edge after rst deasserts.

Configuration
REQ-031 Macro DMEM_ALIGN_CHECK_EN defined: request with req_addr[1:0]!=0 SHALL skip the SRAM cycle, go IDLE->RESP, and respond next cycle with resp_valid=1, resp_err=1, resp_rdata unchanged.
REQ-032 Macro undefined: req_addr[1:0] SHALL be ignored, resp_err tied 0, no error path synthesized.

Structure
REQ-033 Package dmem_pkg SHALL hold the FSM state enum, default SRAM_AW, and the strobe-inactive constants.
REQ-034 One sub-module, sram_wait_cnt (load, decrement, done flag), SHALL implement REQ-028.

Verification
REQ-035 Load addr 0x0000_0010, sram_rdata=0xDEADBEEF, WAIT_CYCLES=2 -> sram_addr=0x4, oe_n low 2 cycles, resp_valid 3 clocks after accept, resp_rdata=0xDEADBEEF.
REQ-036 Store addr 0x20, wdata 0x12345678, be=4'b0011 -> we_n low 2 cycles, be_n=4'b1100, one WHOLD cycle with we_n=1, resp_valid in WHOLD.
REQ-037 req_valid held high for 3 back-to-back loads -> accepts spaced 4 clocks apart, req_ready low between.
REQ-038 rst pulsed low during WR -> strobes high same cycle, no resp_valid; next load completes normally.
REQ-039 With DMEM_ALIGN_CHECK_EN, load addr 0x13 -> no ce_n activity, resp_valid=resp_err=1 one clock after accept; without macro, same request reads word 0x4.
REQ-040 Store with be=4'b0000 -> full WR cycle, be_n=4'b1111, resp_err=0.
